// File: rtl/ti_sbox_pkg.sv
// Shared definitions for the threshold-implementation tower-field AES S-box:
// share geometry plus the polynomial <-> composite basis change helpers.
package ti_sbox_pkg;

    localparam int unsigned SHARE_W = 8;
    localparam int unsigned NSHARES = 3;

    typedef logic [SHARE_W-1:0]              share_t;
    typedef logic [NSHARES-1:0][SHARE_W-1:0] shares_t;

    // Polynomial basis GF(2^8) -> composite GF((2^4)^2) basis.
    function automatic share_t fwd_map(input share_t a);
        share_t b;
        b[7] = a[7] ^ a[4];
        b[6] = a[6] ^ a[4] ^ a[1] ^ a[0];
        b[5] = a[6] ^ a[4];
        b[4] = a[6] ^ a[3] ^ a[1] ^ a[0];
        b[3] = a[7] ^ a[6] ^ a[4];
        b[2] = a[7] ^ a[5] ^ a[2];
        b[1] = a[4] ^ a[3] ^ a[0];
        b[0] = a[6] ^ a[5] ^ a[4] ^ a[1] ^ a[0];
        return b;
    endfunction

    // Output-side inverse: inv_map(fwd_map(x)) == x for every byte.
    function automatic share_t inv_map(input share_t b);
        share_t a;
        a[7] = b[5] ^ b[3];
        a[6] = b[7] ^ b[3];
        a[5] = b[6] ^ b[0];
        a[4] = b[7] ^ b[5] ^ b[3];
        a[3] = b[7] ^ b[6] ^ b[5] ^ b[4] ^ b[3];
        a[2] = b[6] ^ b[5] ^ b[3] ^ b[2] ^ b[0];
        a[1] = b[5] ^ b[4] ^ b[1];
        a[0] = b[6] ^ b[4] ^ b[1];
        return a;
    endfunction

endpackage

// File: rtl/fwd_lin_map.sv
// Combinational forward basis change for a single share.
module fwd_lin_map
    import ti_sbox_pkg::*;
(
    input  logic [SHARE_W-1:0] data_i,
    output logic [SHARE_W-1:0] data_o
);

    assign data_o = fwd_map(data_i);

endmodule

// File: rtl/ti_in_map_pipe.sv
// Two-stage TI input stage: share-wise forward basis map, then optional remask,
// with a bubble-collapsing valid/ready pipeline toward the inversion core.
module ti_in_map_pipe
    import ti_sbox_pkg::*;
#(
    parameter int unsigned SHARES = 3,
    parameter bit          REMASK = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SHARE_W-1:0] in_s0,
    input  logic [SHARE_W-1:0] in_s1,
    input  logic [SHARE_W-1:0] in_s2,
    input  logic [15:0]        rnd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SHARE_W-1:0] out_s0,
    output logic [SHARE_W-1:0] out_s1,
    output logic [SHARE_W-1:0] out_s2,
    output logic               rnd_req
);

    shares_t            in_sh;
    shares_t            map_sh;
    shares_t            s1_q;
    shares_t            s2_d;
    shares_t            s2_q;
    logic               v1_q;
    logic               v2_q;
    logic               en1;
    logic               en2;
    logic [SHARE_W-1:0] r1;
    logic [SHARE_W-1:0] r2;

    assign in_sh = {in_s2, in_s1, in_s0};
    assign r1    = rnd[7:0];
    assign r2    = rnd[15:8];

    for (genvar k = 0; k < SHARES; k++) begin : gen_map
        fwd_lin_map u_map (
            .data_i (in_sh[k]),
            .data_o (map_sh[k])
        );
    end

    // Each stage advances when it is empty or its successor is moving.
    assign en2      = ~v2_q | out_ready;
    assign en1      = ~v1_q | en2;
    assign in_ready = en1;
    assign rnd_req  = en2 & v1_q & REMASK;

    // Share sum is preserved: r1 ^ r2 ^ (r1 ^ r2) cancels.
    always_comb begin
        s2_d = s1_q;
        if (REMASK) begin
            s2_d[0] = s1_q[0] ^ r1;
            s2_d[1] = s1_q[1] ^ r2;
            s2_d[2] = s1_q[2] ^ r1 ^ r2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else if (clr) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            if (en2) v2_q <= v1_q;
            if (en1) v1_q <= in_valid;
        end
    end

    // Data follows its valid; after a flush the contents are hidden by the cleared valids.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            if (en1 && in_valid) s1_q <= map_sh;
            if (en2 && v1_q)     s2_q <= s2_d;
        end
    end

    assign out_valid = v2_q;
    assign out_s0    = s2_q[0];
    assign out_s1    = s2_q[1];
    assign out_s2    = s2_q[2];

endmodule

// File: tb/tb_ti_in_map_pipe.sv
// Directed bench for ti_in_map_pipe: one plain (REMASK=0) and one remasking instance
// share the same stimulus; expected values come from a column-table model of the map.
module tb_ti_in_map_pipe;
    import ti_sbox_pkg::*;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        clr       = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_s0     = 8'h00;
    logic [7:0]  in_s1     = 8'h00;
    logic [7:0]  in_s2     = 8'h00;
    logic [15:0] rnd       = 16'h0000;

    logic       in_ready_p, out_valid_p, rnd_req_p;
    logic [7:0] out_s0_p, out_s1_p, out_s2_p;
    logic       in_ready_m, out_valid_m, rnd_req_m;
    logic [7:0] out_s0_m, out_s1_m, out_s2_m;

    int n_vec = 0;
    int n_err = 0;

    // Images of the single-bit inputs A0..A7 under the forward map.
    localparam logic [7:0] FCOL [8] = '{8'h53, 8'h51, 8'h04, 8'h12, 8'hEB, 8'h05, 8'h79, 8'h8C};

    always #5 clk = ~clk;

    ti_in_map_pipe #(.SHARES(3), .REMASK(1'b0)) u_plain (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready_p),
        .in_s0     (in_s0),
        .in_s1     (in_s1),
        .in_s2     (in_s2),
        .rnd       (rnd),
        .out_valid (out_valid_p),
        .out_ready (out_ready),
        .out_s0    (out_s0_p),
        .out_s1    (out_s1_p),
        .out_s2    (out_s2_p),
        .rnd_req   (rnd_req_p)
    );

    ti_in_map_pipe #(.SHARES(3), .REMASK(1'b1)) u_mask (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready_m),
        .in_s0     (in_s0),
        .in_s1     (in_s1),
        .in_s2     (in_s2),
        .rnd       (rnd),
        .out_valid (out_valid_m),
        .out_ready (out_ready),
        .out_s0    (out_s0_m),
        .out_s1    (out_s1_m),
        .out_s2    (out_s2_m),
        .rnd_req   (rnd_req_m)
    );

    function automatic logic [7:0] fmodel(input logic [7:0] a);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) if (a[i]) b ^= FCOL[i];
        return b;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({out_valid_p, out_valid_m, rnd_req_p, rnd_req_m} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl got %b exp 0000",
                     {out_valid_p, out_valid_m, rnd_req_p, rnd_req_m});
        end
        n_vec++;
        if ({out_s2_p, out_s1_p, out_s0_p, out_s2_m, out_s1_m, out_s0_m} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_data got %h exp 0",
                     {out_s2_p, out_s1_p, out_s0_p, out_s2_m, out_s1_m, out_s0_m});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({in_ready_p, in_ready_m, out_valid_m} !== 3'b110) begin
            n_err++;
            $display("FAIL reset_release got %b exp 110", {in_ready_p, in_ready_m, out_valid_m});
        end
    endtask

    task automatic test_basis();
        logic [7:0] vin  [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
        logic [7:0] vexp [4] = '{8'h53, 8'h8C, 8'h0F, 8'h00};
        out_ready = 1'b1;
        rnd       = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_s0 = vin[i]; in_s1 = 8'h00; in_s2 = 8'h00;
            @(negedge clk);
            n_vec++;
            if (in_ready_p !== 1'b1) begin
                n_err++; $display("FAIL basis_ready[%0d] got %b exp 1", i, in_ready_p);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            n_vec++;
            if ({out_valid_p, rnd_req_p, rnd_req_m} !== 3'b001) begin
                n_err++;
                $display("FAIL basis_lat1[%0d] got %b exp 001", i,
                         {out_valid_p, rnd_req_p, rnd_req_m});
            end
            @(posedge clk); #1;
            @(negedge clk);
            n_vec++;
            if ({out_valid_p, out_s2_p, out_s1_p, out_s0_p} !== {1'b1, 16'h0000, vexp[i]}) begin
                n_err++;
                $display("FAIL basis_plain[%0d] got %b/%h exp 1/%h", i, out_valid_p,
                         {out_s2_p, out_s1_p, out_s0_p}, {16'h0000, vexp[i]});
            end
            n_vec++;
            if ({out_s2_m, out_s1_m, out_s0_m} !== {8'h26, 8'h12, vexp[i] ^ 8'h34}) begin
                n_err++;
                $display("FAIL basis_mask[%0d] got %h exp %h", i, {out_s2_m, out_s1_m, out_s0_m},
                         {8'h26, 8'h12, vexp[i] ^ 8'h34});
            end
            @(posedge clk); #1;
            @(negedge clk);
            n_vec++;
            if (out_valid_p !== 1'b0) begin
                n_err++; $display("FAIL basis_drain[%0d] got %b exp 0", i, out_valid_p);
            end
        end
    endtask

    task automatic test_sharing();
        logic [23:0] q[$];
        logic [23:0] h;
        logic [7:0]  xi, xo;
        int sent = 0, got = 0, cyc = 0;
        out_ready = 1'b1;
        while (got < 1000 && cyc < 5000) begin
            @(posedge clk); #1;
            in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_s0 = 8'($urandom); in_s1 = 8'($urandom); in_s2 = 8'($urandom);
            rnd   = 16'($urandom);
            @(negedge clk);
            n_vec++;
            if (out_valid_p !== out_valid_m) begin
                n_err++; $display("FAIL share_valid got %b exp %b", out_valid_p, out_valid_m);
            end
            if (out_valid_m) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL share_spurious got out_valid=1 exp 0");
                end else begin
                    h  = q.pop_front();
                    got++;
                    xi = h[7:0] ^ h[15:8] ^ h[23:16];
                    xo = out_s0_m ^ out_s1_m ^ out_s2_m;
                    if (xo !== fmodel(xi)) begin
                        n_err++; $display("FAIL share_sum got %h exp %h", xo, fmodel(xi));
                    end
                    n_vec++;
                    if (inv_map(xo) !== xi) begin
                        n_err++; $display("FAIL share_inv got %h exp %h", inv_map(xo), xi);
                    end
                    n_vec++;
                    if ({out_s2_p, out_s1_p, out_s0_p} !==
                        {fmodel(h[23:16]), fmodel(h[15:8]), fmodel(h[7:0])}) begin
                        n_err++;
                        $display("FAIL share_plain got %h exp %h", {out_s2_p, out_s1_p, out_s0_p},
                                 {fmodel(h[23:16]), fmodel(h[15:8]), fmodel(h[7:0])});
                    end
                end
            end
            if (in_valid && in_ready_m) begin
                q.push_back({in_s2, in_s1, in_s0});
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (got != 1000) begin
            n_err++; $display("FAIL share_count got %0d exp 1000", got);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] q[$];
        logic [23:0] prev = 24'h0;
        logic [7:0]  xi;
        logic        stalled = 1'b0;
        logic        exp_rdy;
        int sent = 0, got = 0, cyc = 0;
        while (got < 8 && cyc < 200) begin
            @(posedge clk); #1;
            out_ready = ((cyc / 2) % 2) == 1;
            in_valid  = (sent < 8);
            in_s0 = 8'h10 + 8'(sent); in_s1 = 8'hA5; in_s2 = 8'(sent * 7);
            rnd   = 16'($urandom);
            @(negedge clk);
            exp_rdy = !(q.size() == 2 && !out_ready);
            n_vec++;
            if (in_ready_m !== exp_rdy) begin
                n_err++; $display("FAIL bp_ready[%0d] got %b exp %b", cyc, in_ready_m, exp_rdy);
            end
            if (stalled) begin
                n_vec++;
                if ({out_valid_m, out_s2_m, out_s1_m, out_s0_m} !== {1'b1, prev}) begin
                    n_err++;
                    $display("FAIL bp_hold[%0d] got %b/%h exp 1/%h", cyc, out_valid_m,
                             {out_s2_m, out_s1_m, out_s0_m}, prev);
                end
            end
            if (out_valid_m) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL bp_spurious got out_valid=1 exp 0");
                end else begin
                    xi = q[0][7:0] ^ q[0][15:8] ^ q[0][23:16];
                    if ((out_s0_m ^ out_s1_m ^ out_s2_m) !== fmodel(xi)) begin
                        n_err++;
                        $display("FAIL bp_order[%0d] got %h exp %h", got,
                                 out_s0_m ^ out_s1_m ^ out_s2_m, fmodel(xi));
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        got++;
                    end
                end
            end
            stalled = out_valid_m && !out_ready;
            prev    = {out_s2_m, out_s1_m, out_s0_m};
            if (in_valid && in_ready_m) begin
                q.push_back({in_s2, in_s1, in_s0});
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (got != 8 || q.size() != 0) begin
            n_err++; $display("FAIL bp_count got %0d/%0d exp 8/0", got, q.size());
        end
    endtask

    task automatic test_throughput();
        logic [7:0] eb;
        int got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 260; c++) begin
            @(posedge clk); #1;
            in_valid = (c < 256);
            in_s0 = c[7:0]; in_s1 = 8'h5A; in_s2 = 8'hC3;
            rnd   = 16'($urandom);
            @(negedge clk);
            if (c < 256) begin
                n_vec++;
                if ({in_ready_p, in_ready_m, rnd_req_p} !== 3'b110) begin
                    n_err++;
                    $display("FAIL tput_ready[%0d] got %b exp 110", c,
                             {in_ready_p, in_ready_m, rnd_req_p});
                end
                if (c >= 1) begin
                    n_vec++;
                    if (rnd_req_m !== 1'b1) begin
                        n_err++; $display("FAIL tput_rnd_req[%0d] got %b exp 1", c, rnd_req_m);
                    end
                end
            end
            if (out_valid_m) begin
                eb = got[7:0];
                got++;
                n_vec++;
                if (out_s0_p !== fmodel(eb) ||
                    (out_s0_m ^ out_s1_m ^ out_s2_m) !== fmodel(eb ^ 8'h5A ^ 8'hC3)) begin
                    n_err++;
                    $display("FAIL tput_data[%0d] got %h/%h exp %h/%h", got - 1, out_s0_p,
                             out_s0_m ^ out_s1_m ^ out_s2_m, fmodel(eb),
                             fmodel(eb ^ 8'h5A ^ 8'hC3));
                end
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (got != 256) begin
            n_err++; $display("FAIL tput_count got %0d exp 256", got);
        end
    endtask

    task automatic test_flush(input bit use_rst);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1;
        in_s0 = 8'hAA; in_s1 = 8'h00; in_s2 = 8'h00;
        @(posedge clk); #1;
        in_s0 = 8'h55;
        @(posedge clk); #1;
        in_s0 = 8'h33;
        @(negedge clk);
        n_vec++;
        if ({out_valid_p, in_ready_p, in_ready_m, out_s0_p} !== {3'b100, fmodel(8'hAA)}) begin
            n_err++;
            $display("FAIL flush_full[%0d] got %b/%h exp 100/%h", use_rst,
                     {out_valid_p, in_ready_p, in_ready_m}, out_s0_p, fmodel(8'hAA));
        end
        if (use_rst) rst_n = 1'b0;
        else         clr   = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({out_valid_p, out_valid_m, in_ready_p, in_ready_m} !== 4'b0011) begin
            n_err++;
            $display("FAIL flush_after[%0d] got %b exp 0011", use_rst,
                     {out_valid_p, out_valid_m, in_ready_p, in_ready_m});
        end
        if (use_rst) begin
            n_vec++;
            if ({out_s2_m, out_s1_m, out_s0_m, out_s0_p} !== 32'h0) begin
                n_err++;
                $display("FAIL flush_rst_data got %h exp 0", {out_s2_m, out_s1_m, out_s0_m, out_s0_p});
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_vec++;
            if ({out_valid_p, out_valid_m} !== 2'b00) begin
                n_err++;
                $display("FAIL flush_stale[%0d.%0d] got %b exp 00", use_rst, i,
                         {out_valid_p, out_valid_m});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basis();
        test_sharing();
        test_backpressure();
        test_throughput();
        test_flush(1'b0);
        test_flush(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "bench timeout");
    end

endmodule
